dmem_bridge_8b: RTL and testbench
=================================

DMEM_BRIDGE_8B -- requirements
Module: dmem_bridge_8b

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, ports `clk` and `a_rst`.
REQ-002 Ports SHALL be as follows, clock and reset first:
- `clk`  in  1  – core clock; all state updates on the rising edge.
- `a_rst`  in  1  – asynchronous, active-low reset.
- `core_addr`  in  16  – core data address; byte lane 0 = even byte.
- `core_data_out`  in  16  – write data; [7:0] = lane 0, [15:8] = lane 1.
- `core_be0`  in  1  – lane 0 enable.
- `core_be1`  in  1  – lane 1 enable.
- `core_cmd`  in  1  – 1 = write, 0 = read.
- `core_assert`  in  1  – core request valid; held until `core_rdy`.
- `core_rdy`  out  1  – transaction complete, one-cycle pulse.
- `core_data_in`  out  16  – read data, valid while `core_rdy` = 1.
- `ext_addr`  out  16  – external byte address.
- `ext_wdata`  out  8  – external write byte.
- `ext_we`  out  1  – 1 = external write beat.
- `ext_req`  out  1  – external beat request.
- `ext_rdata`  in  8  – external read byte, valid with `ext_ack`.
- `ext_ack`  in  1  – beat accepted/completed.
- `bus_err`  out  1  – beat timed out; valid with `core_rdy`.

Function
REQ-003 SHALL implement FSM states IDLE, LO, HI, DONE.
REQ-004 In IDLE with `core_assert` = 1, SHALL latch addr, data, be0, be1 and cmd.
- Next state: LO if be0; else HI if be1; else DONE.
REQ-005 Latched values SHALL be used for the whole transaction; core-side input changes after latch SHALL be ignored.
REQ-006 In LO, SHALL drive `ext_req` = 1 with:
- `ext_addr` = {addr[15:1], 1'b0}
- `ext_wdata` = data[7:0]
- `ext_we` = cmd
REQ-007 In HI, SHALL drive `ext_req` = 1 with:
- `ext_addr` = {addr[15:1], 1'b1}
- `ext_wdata` = data[15:8]
- `ext_we` = cmd
REQ-008 A beat SHALL hold `ext_req` and all `ext_*` outputs stable until the cycle `ext_ack` = 1 is sampled; that cycle ends the beat.
REQ-009 On LO beat end, SHALL go to HI if be1, else DONE. On HI beat end, SHALL go to DONE.
REQ-010 On a read beat end, SHALL capture `ext_rdata` into the matching lane of the read register.
- Lanes not enabled SHALL read 0x00.
- The read register SHALL clear on every IDLE latch.
REQ-011 In DONE, SHALL assert `core_rdy` = 1 for exactly one cycle, drive `core_data_in` = read register (0x0000 for writes), then return to IDLE.
REQ-012 `core_rdy` SHALL be 0 in every other state; `ext_req` SHALL be 0 in IDLE and DONE.
REQ-013 The next request SHALL be latchable the cycle after DONE, with no extra idle cycle.
REQ-014 Latency from latch to `core_rdy`, with immediate acks, SHALL be:
- 3 cycles for a 2-lane access
- 2 cycles for a 1-lane access
- 1 cycle with no lanes enabled
REQ-015 `ext_ack` SHALL be ignored in IDLE and DONE.
REQ-016 `core_data_in` outside DONE SHALL hold the last read-register value.

Reset
REQ-017 Asserting `a_rst` = 0 SHALL, immediately and asynchronously:
- force the FSM to IDLE
- set `ext_req` = 0, `ext_we` = 0, `core_rdy` = 0, `bus_err` = 0
- set `ext_addr` = 0x0000, `ext_wdata` = 0x00
- set `core_data_in` = 0x0000 and clear the read register
REQ-018 Reset mid-beat SHALL abandon the transaction with no `core_rdy`; a held `core_assert` SHALL be re-latched on the first clock after release.

Configuration
REQ-019 Macro `DMEM_BRIDGE_TIMEOUT_EN` defined SHALL enable an 8-bit per-beat wait counter.
- The counter clears at each beat start and increments each cycle `ext_req` = 1 and `ext_ack` = 0.
- At count 255, the beat SHALL be aborted: drop `ext_req`, skip remaining beats, go to DONE.
- `bus_err` = 1 SHALL be asserted with that `core_rdy` pulse.
REQ-020 Macro `DMEM_BRIDGE_TIMEOUT_EN` undefined SHALL:
- omit the counter
- tie `bus_err` to 0
- wait indefinitely for `ext_ack`

Verification
REQ-021 Read, addr 0x1234, be0 = be1 = 1, ack every cycle, rdata 0xAB then 0xCD:
- expect `ext_addr` 0x1234 then 0x1235
- expect `core_rdy` on latch+3 with `core_data_in` = 0xCDAB
REQ-022 Write, addr 0x2000, data 0xBEEF, be1 only, ack delayed 4 cycles:
- expect a single beat, `ext_addr` 0x2001, `ext_wdata` 0xBE, `ext_we` = 1
- expect `ext_*` stable for 5 cycles, then `core_rdy`
REQ-023 Read, be0 only, rdata 0x5A: expect `core_data_in` = 0x005A; be0 = be1 = 0: expect `core_rdy` on latch+1, no `ext_req`.
REQ-024 Back-to-back requests with `core_assert` held: expect the second latch on the cycle after the first `core_rdy`; `core_data_in` not corrupted.
REQ-025 `a_rst` = 0 during a LO beat: expect `ext_req` = 0 immediately, no `core_rdy`, and a restart from LO after release.
REQ-026 With `DMEM_BRIDGE_TIMEOUT_EN` defined and `ext_ack` never asserted: expect `core_rdy` with `bus_err` = 1 after 255 wait cycles; undefined: expect no `core_rdy` after 1000 cycles.

Source files
------------

// File: rtl/dmem_bridge_8b.sv
// 16-bit core data port to 8-bit external byte bus bridge; each 16-bit access is split into up to two byte beats.
// Define DMEM_BRIDGE_TIMEOUT_EN to add a per-beat wait counter that aborts a stalled beat and flags bus_err.
module dmem_bridge_8b (
    input  logic        clk,
    input  logic        a_rst,
    input  logic [15:0] core_addr,
    input  logic [15:0] core_data_out,
    input  logic        core_be0,
    input  logic        core_be1,
    input  logic        core_cmd,
    input  logic        core_assert,
    output logic        core_rdy,
    output logic [15:0] core_data_in,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        ext_we,
    output logic        ext_req,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack,
    output logic        bus_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [14:0] addr_q;
    logic [15:0] data_q;
    logic        be0_q;
    logic        be1_q;
    logic        cmd_q;
    logic [15:0] rd_q;
    logic [15:0] hold_q;
    logic        beat_timeout;

    // Byte lane is selected by the beat state, so the core's address LSB is not needed.
    logic unused_addr_lsb;
    assign unused_addr_lsb = core_addr[0];

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;

    // Abort on the cycle the wait count would reach 255, i.e. after 255 unacknowledged cycles.
    assign beat_timeout = ext_req && !ext_ack && (wait_cnt == 8'd254);

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (!ext_req || ext_ack) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == IDLE && core_assert) begin
                err_q <= 1'b0;
            end else if (beat_timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus_err = err_q && (state == DONE);
`else
    assign beat_timeout = 1'b0;
    assign bus_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            be0_q  <= 1'b0;
            be1_q  <= 1'b0;
            cmd_q  <= 1'b0;
            rd_q   <= '0;
            hold_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_assert) begin
                        addr_q <= core_addr[15:1];
                        data_q <= core_data_out;
                        be0_q  <= core_be0;
                        be1_q  <= core_be1;
                        cmd_q  <= core_cmd;
                        rd_q   <= '0;
                        if (core_be0) begin
                            state <= LO;
                        end else if (core_be1) begin
                            state <= HI;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                LO: begin
                    if (ext_ack) begin
                        if (!cmd_q) begin
                            rd_q[7:0] <= ext_rdata;
                        end
                        state <= be1_q ? HI : DONE;
                    end else if (beat_timeout) begin
                        state <= DONE;
                    end
                end
                HI: begin
                    if (ext_ack) begin
                        if (!cmd_q) begin
                            rd_q[15:8] <= ext_rdata;
                        end
                        state <= DONE;
                    end else if (beat_timeout) begin
                        state <= DONE;
                    end
                end
                default: begin
                    hold_q <= rd_q;
                    state  <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ext_req   = 1'b0;
        ext_addr  = '0;
        ext_wdata = '0;
        ext_we    = 1'b0;
        case (state)
            LO: begin
                ext_req   = 1'b1;
                ext_addr  = {addr_q, 1'b0};
                ext_wdata = data_q[7:0];
                ext_we    = cmd_q;
            end
            HI: begin
                ext_req   = 1'b1;
                ext_addr  = {addr_q, 1'b1};
                ext_wdata = data_q[15:8];
                ext_we    = cmd_q;
            end
            default: ;
        endcase
    end

    assign core_rdy     = (state == DONE);
    assign core_data_in = (state == DONE) ? rd_q : hold_q;

endmodule

// File: tb/tb_dmem_bridge_8b.sv
// Directed self-checking bench for dmem_bridge_8b; expected values are hand-derived constants.
// Honours DMEM_BRIDGE_TIMEOUT_EN for the stalled-beat scenario.
module tb_dmem_bridge_8b;

    logic        clk;
    logic        a_rst;
    logic [15:0] core_addr;
    logic [15:0] core_data_out;
    logic        core_be0;
    logic        core_be1;
    logic        core_cmd;
    logic        core_assert;
    logic        core_rdy;
    logic [15:0] core_data_in;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_we;
    logic        ext_req;
    logic [7:0]  ext_rdata;
    logic        ext_ack;
    logic        bus_err;

    int unsigned checks;
    int unsigned failures;

    dmem_bridge_8b dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .core_addr    (core_addr),
        .core_data_out(core_data_out),
        .core_be0     (core_be0),
        .core_be1     (core_be1),
        .core_cmd     (core_cmd),
        .core_assert  (core_assert),
        .core_rdy     (core_rdy),
        .core_data_in (core_data_in),
        .ext_addr     (ext_addr),
        .ext_wdata    (ext_wdata),
        .ext_we       (ext_we),
        .ext_req      (ext_req),
        .ext_rdata    (ext_rdata),
        .ext_ack      (ext_ack),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance past the next rising edge so outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [15:0] addr, input logic [15:0] data,
                           input logic be0, input logic be1, input logic cmd);
        core_addr     = addr;
        core_data_out = data;
        core_be0      = be0;
        core_be1      = be1;
        core_cmd      = cmd;
        core_assert   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rdy_seen;
        checks        = 0;
        failures      = 0;
        a_rst         = 1'b0;
        core_addr     = '0;
        core_data_out = '0;
        core_be0      = 1'b0;
        core_be1      = 1'b0;
        core_cmd      = 1'b0;
        core_assert   = 1'b0;
        ext_rdata     = '0;
        ext_ack       = 1'b0;
        #23;
        check("rst_rdy", {15'd0, core_rdy}, 16'h0000);
        check("rst_req", {15'd0, ext_req}, 16'h0000);
        check("rst_addr", ext_addr, 16'h0000);
        check("rst_data_in", core_data_in, 16'h0000);
        check("rst_err", {15'd0, bus_err}, 16'h0000);
        a_rst = 1'b1;
        tick();

        // Two-lane read, immediate acks.
        request(16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0);
        ext_ack   = 1'b1;
        ext_rdata = 8'hAB;
        tick();
        core_assert = 1'b0;
        core_addr   = 16'hFFFF;
        check("rd2_lo_req", {15'd0, ext_req}, 16'h0001);
        check("rd2_lo_addr", ext_addr, 16'h1234);
        check("rd2_lo_we", {15'd0, ext_we}, 16'h0000);
        check("rd2_lo_rdy", {15'd0, core_rdy}, 16'h0000);
        tick();
        ext_rdata = 8'hCD;
        check("rd2_hi_addr", ext_addr, 16'h1235);
        tick();
        ext_ack = 1'b0;
        check("rd2_rdy", {15'd0, core_rdy}, 16'h0001);
        check("rd2_data", core_data_in, 16'hCDAB);
        check("rd2_req_done", {15'd0, ext_req}, 16'h0000);
        check("rd2_err", {15'd0, bus_err}, 16'h0000);
        tick();
        check("rd2_rdy_drop", {15'd0, core_rdy}, 16'h0000);
        check("rd2_hold", core_data_in, 16'hCDAB);

        // Upper-lane write, ack after four wait cycles.
        request(16'h2000, 16'hBEEF, 1'b0, 1'b1, 1'b1);
        tick();
        core_assert   = 1'b0;
        core_data_out = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            check("wr_req", {15'd0, ext_req}, 16'h0001);
            check("wr_addr", ext_addr, 16'h2001);
            check("wr_wdata", {8'd0, ext_wdata}, 16'h00BE);
            check("wr_we", {15'd0, ext_we}, 16'h0001);
            check("wr_rdy_early", {15'd0, core_rdy}, 16'h0000);
            if (i == 4) ext_ack = 1'b1;
            tick();
        end
        ext_ack = 1'b0;
        check("wr_rdy", {15'd0, core_rdy}, 16'h0001);
        check("wr_data_in", core_data_in, 16'h0000);
        tick();

        // Lower-lane read; an ack during DONE must be ignored.
        request(16'h0101, 16'h0000, 1'b1, 1'b0, 1'b0);
        ext_ack   = 1'b1;
        ext_rdata = 8'h5A;
        tick();
        core_assert = 1'b0;
        check("rd0_addr", ext_addr, 16'h0100);
        tick();
        check("rd0_rdy", {15'd0, core_rdy}, 16'h0001);
        check("rd0_data", core_data_in, 16'h005A);
        tick();
        ext_ack = 1'b0;
        check("rd0_idle_req", {15'd0, ext_req}, 16'h0000);

        // No lanes enabled: DONE straight after latch.
        request(16'h3000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        core_assert = 1'b0;
        check("none_rdy", {15'd0, core_rdy}, 16'h0001);
        check("none_req", {15'd0, ext_req}, 16'h0000);
        check("none_data", core_data_in, 16'h0000);
        tick();

        // Back-to-back with core_assert held.
        request(16'h0400, 16'h0000, 1'b1, 1'b0, 1'b0);
        ext_ack   = 1'b1;
        ext_rdata = 8'h11;
        tick();
        tick();
        check("b2b_rdy1", {15'd0, core_rdy}, 16'h0001);
        check("b2b_data1", core_data_in, 16'h0011);
        request(16'h0500, 16'h0000, 1'b0, 1'b1, 1'b0);
        ext_rdata = 8'h22;
        tick();
        check("b2b_idle_rdy", {15'd0, core_rdy}, 16'h0000);
        check("b2b_idle_hold", core_data_in, 16'h0011);
        tick();
        core_assert = 1'b0;
        check("b2b_hi_req", {15'd0, ext_req}, 16'h0001);
        check("b2b_hi_addr", ext_addr, 16'h0501);
        tick();
        ext_ack = 1'b0;
        check("b2b_rdy2", {15'd0, core_rdy}, 16'h0001);
        check("b2b_data2", core_data_in, 16'h2200);
        tick();

        // Reset during a LO beat, then restart with the held request.
        request(16'h4000, 16'h0000, 1'b1, 1'b1, 1'b0);
        tick();
        check("rst_mid_req_before", {15'd0, ext_req}, 16'h0001);
        #2 a_rst = 1'b0;
        #1;
        check("rst_mid_req", {15'd0, ext_req}, 16'h0000);
        check("rst_mid_addr", ext_addr, 16'h0000);
        check("rst_mid_rdy", {15'd0, core_rdy}, 16'h0000);
        @(posedge clk);
        #3 a_rst = 1'b1;
        tick();
        check("restart_req", {15'd0, ext_req}, 16'h0001);
        check("restart_addr", ext_addr, 16'h4000);
        core_assert = 1'b0;
        ext_ack   = 1'b1;
        ext_rdata = 8'h77;
        tick();
        ext_rdata = 8'h88;
        tick();
        ext_ack = 1'b0;
        check("restart_rdy", {15'd0, core_rdy}, 16'h0001);
        check("restart_data", core_data_in, 16'h8877);
        tick();

        // Stalled beat: ext_ack never asserted.
        request(16'h6000, 16'h0000, 1'b1, 1'b1, 1'b0);
        tick();
        core_assert = 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
        n = 0;
        while (!core_rdy && n < 1000) begin
            tick();
            n++;
        end
        check("to_wait_cycles", n[15:0], 16'd255);
        check("to_rdy", {15'd0, core_rdy}, 16'h0001);
        check("to_err", {15'd0, bus_err}, 16'h0001);
        check("to_req", {15'd0, ext_req}, 16'h0000);
        check("to_data", core_data_in, 16'h0000);
        tick();
        check("to_err_clear", {15'd0, bus_err}, 16'h0000);
`else
        rdy_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            if (core_rdy) rdy_seen++;
            tick();
        end
        check("stall_rdy_count", rdy_seen[15:0], 16'd0);
        check("stall_req", {15'd0, ext_req}, 16'h0001);
        check("stall_err", {15'd0, bus_err}, 16'h0000);
        a_rst = 1'b0;
        #3 a_rst = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
